// File: rtl/pipes.sv
// Shared pipeline types for the fetch stage: F/D payload, fetch FSM states, reset PC.
package pipes;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [63:0] pc;
    } fetch_data_t;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        DROP,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: redirect target has priority over the sequential +4 adder.
// FETCH_MISALIGN_CHECK_EN keeps the raw target low bits so the caller can flag them.
module pc_next (
    input  logic [63:0] pc,
    input  logic        advance,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] next_pc
);

    logic [63:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target = redirect_pc;
`else
    assign target = redirect_pc & ~64'h3;
`endif

    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = target;
        end else if (advance) begin
            next_pc = pc + 64'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding bus FSM, hold buffer and F/D register.
// Optional FETCH_MISALIGN_CHECK_EN adds the misalign port and the HALT state.
module fetch_stage
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output fetch_data_t out_data
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         boot_q;
    fetch_data_t  fd_q, fd_d;
    logic         fd_valid_q, fd_valid_d;
    fetch_data_t  hold_q, hold_d;
    logic         advance;
    logic         req_fire;
    logic         data_here;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic         misalign_q, misalign_d;
    assign misalign = misalign_q;
`endif

    // Requests start one cycle after reset release, so the bus never sees one during reset.
    assign ireq_valid = boot_q && (state_q == REQ);
    assign ireq_addr  = pc_q;
    assign out_valid  = fd_valid_q;
    assign out_data   = fd_q;

    assign req_fire  = ireq_valid && iresp_addr_ok;
    assign data_here = iresp_data_ok && ((state_q == WAIT) || ((state_q == REQ) && req_fire));

    pc_next u_pc_next (
        .pc          (pc_q),
        .advance     (advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .next_pc     (pc_d)
    );

    always_comb begin
        state_d    = state_q;
        fd_d       = fd_q;
        fd_valid_d = fd_valid_q;
        hold_d     = hold_q;
        advance    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (!stall) begin
            fd_valid_d = 1'b0;
        end

        case (state_q)
            REQ: begin
                if (req_fire && !iresp_data_ok) begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (!stall) begin
                    fd_d       = hold_q;
                    fd_valid_d = 1'b1;
                    state_d    = REQ;
                end
            end
            DROP: begin
                if (iresp_data_ok) begin
                    state_d = REQ;
                end
            end
            WAIT, HALT: ;
            default: state_d = REQ;
        endcase

        if (data_here) begin
            advance = 1'b1;
            if (!stall || !fd_valid_q) begin
                fd_d       = '{instruction: iresp_data, pc: pc_q};
                fd_valid_d = 1'b1;
                state_d    = REQ;
            end else begin
                hold_d  = '{instruction: iresp_data, pc: pc_q};
                state_d = HOLD;
            end
        end

        // Redirect overrides delivery and stall; any in-flight response is dropped.
        if (redirect) begin
            fd_valid_d = 1'b0;
            case (state_q)
                REQ:     state_d = (req_fire && !iresp_data_ok) ? DROP : REQ;
                WAIT:    state_d = iresp_data_ok ? REQ : DROP;
                DROP:    state_d = iresp_data_ok ? REQ : DROP;
                default: state_d = REQ;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                misalign_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            boot_q     <= 1'b0;
            fd_q       <= '0;
            fd_valid_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_q     <= 1'b1;
            fd_q       <= fd_d;
            fd_valid_q <= fd_valid_d;
            hold_q     <= hold_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector bench for fetch_stage; FETCH_MISALIGN_CHECK_EN adds HALT checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [95:0] out_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .out_valid     (out_valid),
        .out_data      (out_data)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Row: outputs expected at this negedge, then inputs driven for the following posedge.
    typedef struct {
        logic        stall;
        logic        redirect;
        logic [63:0] rpc;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [95:0] e_od;
    } vec_t;

    localparam int NumVec = 20;
    vec_t vecs[NumVec];

    function automatic vec_t mk(input logic s, input logic r, input logic [63:0] rpc,
                                input logic aok, input logic dok, input logic [31:0] d,
                                input logic e_iv, input logic [63:0] e_addr,
                                input logic e_ov, input logic [95:0] e_od);
        vec_t v;
        v.stall = s;   v.redirect = r; v.rpc = rpc; v.aok = aok; v.dok = dok; v.data = d;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_od = e_od;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [63:0] rpc,
                         input logic aok, input logic dok, input logic [31:0] d);
        stall = s; redirect = r; redirect_pc = rpc;
        iresp_addr_ok = aok; iresp_data_ok = dok; iresp_data = d;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 1, 0, 0,             1, 64'h8000_0000, 0, '0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0,             0, 0, 0, '0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 32'h0000_0513, 0, 0, 0, '0);
        vecs[3]  = mk(0, 0, 0, 1, 1, 32'h0010_0093, 1, 64'h8000_0004,
                      1, {32'h0000_0513, 64'h8000_0000});
        vecs[4]  = mk(1, 0, 0, 1, 0, 0,             1, 64'h8000_0008,
                      1, {32'h0010_0093, 64'h8000_0004});
        vecs[5]  = mk(1, 0, 0, 0, 1, 32'h0020_0113, 0, 0,
                      1, {32'h0010_0093, 64'h8000_0004});
        vecs[6]  = mk(1, 0, 0, 0, 0, 0,             0, 0,
                      1, {32'h0010_0093, 64'h8000_0004});
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,             0, 0,
                      1, {32'h0010_0093, 64'h8000_0004});
        vecs[8]  = mk(0, 0, 0, 1, 0, 0,             1, 64'h8000_000C,
                      1, {32'h0020_0113, 64'h8000_0008});
        vecs[9]  = mk(0, 1, 64'h8000_0100, 0, 0, 0, 0, 0, 0, '0);
        vecs[10] = mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, '0);
        vecs[11] = mk(0, 0, 0, 1, 1, 32'h0030_0193, 1, 64'h8000_0100, 0, '0);
        vecs[12] = mk(1, 1, 64'h8000_0200, 0, 0, 0, 1, 64'h8000_0104,
                      1, {32'h0030_0193, 64'h8000_0100});
        vecs[13] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1, 64'h8000_0200, 0, '0);
        vecs[14] = mk(0, 0, 0, 1, 1, 32'h0040_0213, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0,             1, 64'h0,
                      1, {32'h0040_0213, 64'hFFFF_FFFF_FFFF_FFFC});
        vecs[16] = mk(0, 1, 64'h8000_0300, 1, 0, 0, 1, 64'h0, 0, '0);
        vecs[17] = mk(0, 1, 64'h8000_0400, 0, 0, 0, 0, 0, 0, '0);
        vecs[18] = mk(0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, '0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0,             1, 64'h8000_0400, 0, '0);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check("rst_ireq_valid", {95'd0, ireq_valid}, 96'd0);
        check("rst_out_valid", {95'd0, out_valid}, 96'd0);
        check("rst_out_data", out_data, 96'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", {95'd0, misalign}, 96'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_ireq_valid", i), {95'd0, ireq_valid}, {95'd0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                check($sformatf("v%0d_ireq_addr", i), {32'd0, ireq_addr}, {32'd0, vecs[i].e_addr});
            end
            check($sformatf("v%0d_out_valid", i), {95'd0, out_valid}, {95'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
            end
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].aok, vecs[i].dok,
                  vecs[i].data);
        end

        // Reset in WAIT abandons the request; fetch restarts at RESET_PC.
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("midrst_wait_iv", {95'd0, ireq_valid}, 96'd0);
        #1 reset = 1'b0;
        #1;
        check("midrst_iv", {95'd0, ireq_valid}, 96'd0);
        check("midrst_ov", {95'd0, out_valid}, 96'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart_iv", {95'd0, ireq_valid}, 96'd1);
        check("restart_addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0000});

`ifdef FETCH_MISALIGN_CHECK_EN
        drive(0, 1, 64'h8000_0102, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("halt_misalign", {95'd0, misalign}, 96'd1);
        check("halt_iv", {95'd0, ireq_valid}, 96'd0);
        @(negedge clk);
        check("halt_misalign_sticky", {95'd0, misalign}, 96'd1);
        check("halt_iv_held", {95'd0, ireq_valid}, 96'd0);
        drive(0, 1, 64'h8000_0200, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("unhalt_misalign", {95'd0, misalign}, 96'd0);
        check("unhalt_iv", {95'd0, ireq_valid}, 96'd1);
        check("unhalt_addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0200});
`else
        drive(0, 1, 64'h8000_0503, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("align_iv", {95'd0, ireq_valid}, 96'd1);
        check("align_addr", {32'd0, ireq_addr}, {32'd0, 64'h8000_0500});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the PC register, drives the instruction bus with one outstanding request at a time, and delivers `{instruction, pc}` as a `fetch_data_t` to the decode stage through a registered output. It honours hazard-unit stalls and execute-stage redirects. Redirects cover taken branches, `jal` and `jalr`.

## Interface
- `RESET_PC`, `64'h0000_0000_8000_0000`, first fetch address after reset
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit holds the F/D register (`hazard_data_out.stall`)
- `redirect`  in  1  execute stage requests a PC change
- `redirect_pc`  in  64  new fetch target
- `ireq_valid`  out  1  instruction-bus request valid
- `ireq_addr`  out  64  request address
- `iresp_addr_ok`  in  1  bus accepted the address this cycle
- `iresp_data_ok`  in  1  instruction data valid this cycle
- `iresp_data`  in  32  instruction word
- `out_valid`  out  1  F/D register holds a valid instruction
- `out_data`  out  96  `fetch_data_t {instruction, pc}`
- `misalign`  out  1  misaligned redirect detected; exists only with `FETCH_MISALIGN_CHECK_EN`

## Operation
- Reset (`reset`=0, async) sets the following:
  - `pc`=`RESET_PC`, state REQ, hold buffer empty.
  - `out_valid`=0, `out_data`=0, `ireq_valid`=0, `misalign`=0.
- The states are REQ, WAIT, DROP and HOLD.
- REQ:
  - `ireq_valid`=1 and `ireq_addr`=`pc`.
  - On `iresp_addr_ok`, go to WAIT.
  - If `iresp_data_ok` also arrives in the same cycle, it is handled as WAIT-with-data in that cycle.
- WAIT:
  - `ireq_valid`=0.
  - On `iresp_data_ok`, `{iresp_data, pc}` is delivered and `pc`←`pc`+4 (64-bit, wraps modulo 2^64).
  - Delivery goes to the F/D register when `stall`=0 or `out_valid`=0, and the next state is REQ.
  - Otherwise delivery goes to the hold buffer and the next state is HOLD.
- HOLD:
  - No bus request is issued.
  - When `stall` falls, the buffer moves to the F/D register and the next state is REQ.
- DROP:
  - Waits for `iresp_data_ok`, discards the data, then goes to REQ.
- F/D register:
  - If `stall`=1, it keeps its value.
  - If `stall`=0 and nothing is delivered, `out_valid`←0.
- `redirect` has priority over everything, including `stall`:
  - Next cycle `out_valid`=0, the hold buffer is emptied, and `pc`=`redirect_pc`.
  - In REQ without `iresp_addr_ok`, the request is retracted and re-issued with the new address next cycle.
  - In REQ with `iresp_addr_ok`, or in WAIT without `iresp_data_ok`, the next state is DROP.
  - In WAIT with `iresp_data_ok`, or in HOLD, the data is discarded and the next state is REQ.
  - In DROP, the state stays DROP with the new `pc`.
  - An `iresp_data_ok` in that same cycle ends DROP.
- At most one request is outstanding.
- `ireq_addr` is stable while `ireq_valid`=1, except when a redirect retracts the request.

## Timing
- With `iresp_addr_ok` at cycle t and `iresp_data_ok` at t+k, `out_valid`=1 from t+k+1.
- With a zero-wait bus (addr_ok and data_ok in the same cycle), peak throughput is one instruction every cycle.
- A redirect asserted at cycle t:
  - Next request `ireq_addr`=`redirect_pc` at t+1, unless the state is DROP.
  - `out_valid`=0 at t+1.
- A stall release at cycle t while in HOLD gives the buffered instruction on `out_data` at t+1.
- The first request is issued the cycle after `reset` rises.
- Reset asserted mid-transaction abandons the request immediately.
  - The bus is expected to be reset with the same signal.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `misalign`=1 (sticky) and enters HALT, a fifth state with no requests.
  - Only the next aligned redirect leaves HALT, clearing `misalign`.
- Undefined:
  - `redirect_pc[1:0]` is forced to 0.
  - No `misalign` port and no HALT state.

## Structure
- The `pipes` package holds:
  - `fetch_data_t`
  - the new `fetch_state_t` enum (REQ, WAIT, DROP, HOLD, HALT)
  - `PC_RESET` as the default for `RESET_PC`
- The 64-bit PC adder and redirect mux live in sub-module `pc_next` (combinational).
- The FSM, hold buffer and F/D register live in `fetch_stage`.

## Test plan
- Reset release, bus addr_ok same cycle, data_ok 2 cycles later with `32'h00000513`:
  - `ireq_addr`=`0x80000000`.
  - `out_data`=`{0x00000513, 0x80000000}` and `out_valid`=1 one cycle after data_ok.
  - Next `ireq_addr`=`0x80000004`.
- `stall`=1 while data_ok returns with `out_valid`=1:
  - The F/D register is unchanged and the state is HOLD.
  - `stall`→0 gives the buffered word on the next cycle.
  - No request is issued while in HOLD.
- `redirect`=1 to `0x80000100` while in WAIT:
  - The next data_ok is dropped and `out_valid` stays 0.
  - The following request address is `0x80000100`.
- `redirect` and `stall` asserted together with `out_valid`=1:
  - `out_valid`=0 next cycle and `pc`=`redirect_pc`.
- PC `0xFFFF_FFFF_FFFF_FFFC` fetched: next `ireq_addr`=0.
- With the macro defined, redirect to `0x80000102`:
  - `misalign`=1 and `ireq_valid` stays 0.
  - Redirect to `0x80000200`: `misalign`=0 and a request is issued to `0x80000200`.
